mdu: RTL and testbench
======================

Name: mdu

Overview:
- Iterative-latency multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded A/B operands as the ALU and holds the architectural HI/LO registers.
- Its read-out (mfhi/mflo) is muxed into the EX result path alongside the ALU result S.
- Exposes busy so the hazard unit stalls dependent MD instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd); must be >= 1.
- DIV_CYCLES, 10, busy duration for div/divu; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
- A  input  32  operand rs (forwarded)
- B  input  32  operand rt (forwarded)
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved/madd
- start  input  1  op valid this cycle; the instruction is in EX and not flushed
- rd_sel  input  1  read select: 0 -> out=LO, 1 -> out=HI
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- out  output  32  combinational: rd_sel ? hi : lo

Behaviour:
- Reset (reset==0 at edge): HI=0, LO=0, count=0, busy=0, pending result discarded. Reset has priority over all other inputs, including mid-operation.
- State:
  - count (width sufficient for max(MULT_CYCLES, DIV_CYCLES)).
  - 64-bit pending register {p_hi, p_lo}.
  - busy = (count != 0), registered-derived, no combinational path from start.
- Accept rule: op is accepted only when start==1 and busy==0. start while busy==1 is ignored entirely: no state change, no error.
- mult/multu accept:
  - {p_hi, p_lo} <= 64-bit product, signed or unsigned respectively.
  - count <= MULT_CYCLES.
- div/divu accept:
  - p_lo <= quotient, p_hi <= remainder; signed division truncates toward zero, remainder takes the sign of A.
  - count <= DIV_CYCLES.
- Divide boundaries:
  - B==0 (div or divu): quotient 0xFFFFFFFF, remainder A.
  - div 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Countdown: each edge with count>0 does count <= count-1. At the edge where count==1: HI <= p_hi, LO <= p_lo, count <= 0.
- Timing: start sampled at edge k -> busy high for exactly N cycles (edges k+1..k+N), HI/LO show the new value after edge k+N, the same edge busy falls.
- During busy, hi/lo/out keep the old values (no partial results visible).
- mthi/mtlo accept: HI <= A (mthi) or LO <= A (mtlo) at that edge. Single cycle, busy stays 0.
- op==0 with start, or op==7 without the feature: no effect.
- Back-to-back: a new start in the cycle right after busy falls is accepted normally.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 7 = madd. On accept, {p_hi, p_lo} <= {HI, LO} + signed(A)*signed(B), modulo 2^64, and count <= MULT_CYCLES. The accumulate base is the HI/LO value at the accept edge.
- Undefined: op 7 is a no-op, busy is not raised, no logic is generated.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=0x00000002 -> busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE. During busy HI=LO=0.
- multu A=0xFFFFFFFF B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE. div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7 B=0 -> LO=0xFFFFFFFF, HI=0x00000007. div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> busy stays 0; out=0x12345678 with rd_sel=1 and 0x9ABCDEF0 with rd_sel=0.
- divu 100/7 started; at busy cycle 3 issue mult 3*3 and mtlo 0x55 with start=1 -> both ignored; final LO=14, HI=2, busy exactly 10 cycles.
- multu 5*5 started; reset=0 at busy cycle 2 -> next cycle busy=0, HI=LO=0. After release, a new mult 3*4 completes with LO=12. With MDU_MADD_EN: HI:LO=0:12, madd 0xFFFFFFFF*1 -> LO=11, HI=0.

Source files
------------

// File: rtl/mdu.sv
// Iterative-latency multiply/divide unit holding the HI/LO registers beside the ALU.
// Optional multiply-accumulate (op 7 = madd) is enabled by defining MDU_MADD_EN.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } op_e;

  op_e           op_q;
  logic [CW-1:0] count;
  logic [63:0]   pend;
  logic          accept;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          div_signed;
  logic          neg_a;
  logic          neg_b;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   mag_q;
  logic [31:0]   mag_r;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic          load_en;
  logic [63:0]   load_val;
  logic [CW-1:0] load_count;

  assign op_q   = op_e'(op);
  assign busy   = (count != '0);
  assign accept = start && !busy;
  assign out    = rd_sel ? hi : lo;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes so one unsigned divider serves both div and divu.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    neg_a      = div_signed & A[31];
    neg_b      = div_signed & B[31];
    mag_a      = neg_a ? -A : A;
    mag_b      = neg_b ? -B : B;
    mag_q      = '1;
    mag_r      = mag_a;
    if (mag_b != 32'd0) begin
      mag_q = mag_a / mag_b;
      mag_r = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? -mag_q : mag_q;
    rem = neg_a ? -mag_r : mag_r;
    if (B == 32'd0) begin
      quo = '1;
      rem = A;
    end
  end

  always_comb begin
    load_en    = 1'b0;
    load_val   = pend;
    load_count = '0;
    if (accept) begin
      case (op_q)
        OP_MULT: begin
          load_en    = 1'b1;
          load_val   = prod_s;
          load_count = MULT_LOAD;
        end
        OP_MULTU: begin
          load_en    = 1'b1;
          load_val   = prod_u;
          load_count = MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          load_en    = 1'b1;
          load_val   = {rem, quo};
          load_count = DIV_LOAD;
        end
`ifdef MDU_MADD_EN
        OP_MADD: begin
          load_en    = 1'b1;
          load_val   = {hi, lo} + prod_s;
          load_count = MULT_LOAD;
        end
`endif
        default: ;
      endcase
    end
  end

  // The pending result is only copied into HI/LO on the final countdown edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi    <= '0;
      lo    <= '0;
      pend  <= '0;
      count <= '0;
    end else begin
      if (load_en) begin
        pend  <= load_val;
        count <= load_count;
      end else if (count != '0) begin
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          hi <= pend[63:32];
          lo <= pend[31:0];
        end
      end
      if (accept && op_q == OP_MTHI) hi <= A;
      if (accept && op_q == OP_MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        start;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .rd_sel(rd_sel), .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the architectural HI:LO value.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] res;
    res = cur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: res = 64'(sa * sb);
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd5: res = {a, cur[31:0]};
      3'd6: res = {cur[63:32], a};
      3'd7: if (MADD) res = cur + 64'(sa * sb);
      default: ;
    endcase
    return res;
  endfunction

  function automatic int ref_cycles(input logic [2:0] o);
    case (o)
      3'd1, 3'd2: return MC;
      3'd3, 3'd4: return DC;
      3'd7:       return MADD ? MC : 0;
      default:    return 0;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check32({name, " hi"}, hi, exp_hi);
    check32({name, " lo"}, lo, exp_lo);
    rd_sel = 1'b0;
    #1;
    check32({name, " out(lo)"}, out, exp_lo);
    rd_sel = 1'b1;
    #1;
    check32({name, " out(hi)"}, out, exp_hi);
  endtask

  // Issues one op, counts busy cycles, and checks HI/LO stay old until completion.
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int exp_cycles,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int cycles;
    old_hi = m_hi;
    old_lo = m_lo;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
    cycles = 0;
    while (busy && cycles < 200) begin
      check32({name, " hold hi"}, hi, old_hi);
      check32({name, " hold lo"}, lo, old_lo);
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (cycles != exp_cycles) begin
      errors++;
      $display("[TB] FAIL %s busy cycles: got %0d expected %0d", name, cycles, exp_cycles);
    end
    checkOutput(name, exp_hi, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] exp;
    logic [2:0]  o;
    logic [31:0] a, b;
    int cycles;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, MC, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult -1*2"};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, MC, 32'h00000001, 32'hFFFFFFFE, "multu"};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, DC, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    vecs[3]  = '{3'd4, 32'h00000007, 32'h00000000, DC, 32'h00000007, 32'hFFFFFFFF, "divu 7/0"};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000, "div ovf"};
    vecs[5]  = '{3'd5, 32'h12345678, 32'h0,        0,  32'h12345678, 32'h80000000, "mthi"};
    vecs[6]  = '{3'd6, 32'h9ABCDEF0, 32'h0,        0,  32'h12345678, 32'h9ABCDEF0, "mtlo"};
    vecs[7]  = '{3'd0, 32'h0000DEAD, 32'h1,        0,  32'h12345678, 32'h9ABCDEF0, "op none"};
    vecs[8]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, DC, 32'hFFFFFFF9, 32'hFFFFFFFF, "div -7/0"};
    vecs[9]  = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, DC, 32'hFFFFFFFF, 32'h00000003, "div -7/-2"};
    vecs[10] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, DC, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
    vecs[11] = '{3'd7, 32'h00000002, 32'h00000003, MADD ? MC : 0,
                 MADD ? 32'h00000002 : 32'h00000001, MADD ? 32'h00000003 : 32'hFFFFFFFD, "op7"};

    reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0; rd_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset busy: got %b expected 0", busy);
    end
    check32("reset hi", hi, 32'h0);
    check32("reset lo", lo, 32'h0);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles,
                    vecs[i].exp_hi, vecs[i].exp_lo);

    $display("[TB] starts while busy are ignored");
    op = 3'd4; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    cycles = 0;
    while (busy && cycles < 200) begin
      if (cycles == 2) begin
        op = 3'd1; A = 32'd3; B = 32'd3; start = 1'b1;
      end else if (cycles == 3) begin
        op = 3'd6; A = 32'h55; start = 1'b1;
      end else begin
        op = 3'd0; start = 1'b0;
      end
      check32("ignore hold hi", hi, m_hi);
      check32("ignore hold lo", lo, m_lo);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0; op = 3'd0;
    checks++;
    if (cycles != DC) begin
      errors++;
      $display("[TB] FAIL ignore busy cycles: got %0d expected %0d", cycles, DC);
    end
    checkOutput("divu 100/7", 32'd2, 32'd14);
    m_hi = 32'd2;
    m_lo = 32'd14;

    $display("[TB] reset during operation");
    op = 3'd2; A = 32'd5; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop busy: got %b expected 1", busy);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop reset busy: got %b expected 0", busy);
    end
    check32("midop reset hi", hi, 32'h0);
    check32("midop reset lo", lo, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check32("no late writeback lo", lo, 32'h0);
    m_hi = '0;
    m_lo = '0;
    applyStimulus("mult 3*4", 3'd1, 32'd3, 32'd4, MC, 32'd0, 32'd12);
    if (MADD)
      applyStimulus("madd -1*1", 3'd7, 32'hFFFFFFFF, 32'd1, MC, 32'd0, 32'd11);

    $display("[TB] randomized operations against reference model");
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      exp = ref_result(o, a, b, {m_hi, m_lo});
      applyStimulus($sformatf("rand%0d op%0d", i, o), o, a, b, ref_cycles(o),
                    exp[63:32], exp[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
